// File: rtl/roulette_pkg.sv
// roulette_pkg: shared opcode constants, FSM state type and slot-width helper
package roulette_pkg;
  localparam logic [5:0] NO_KEY = 6'b111111;
  localparam logic [5:0] SPIN = 6'b111110;
  localparam logic [5:0] UNDO = 6'b111101;
  typedef enum logic [1:0] {ACCEPT, LOCKED, CLEAR} state_t;
  function automatic int slot_w(input int color_w, input int opcode_w);
    return color_w + opcode_w;
  endfunction
endpackage

// File: rtl/pulse_edge.sv
// pulse_edge: rising-edge detector with registered previous value
module pulse_edge (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);
  logic prev;
  always_ff @(posedge clock) prev <= reset ? 1'b0 : din;
  assign rise = din & ~prev;
endmodule

// File: rtl/bet_ledger.sv
// bet_ledger: captures one {colour, opcode} bet per key press, with undo, spin lock and clear
module bet_ledger
  import roulette_pkg::*;
#(
  parameter int N_BETS = 12,
  parameter int OPCODE_W = 6,
  parameter int COLOR_W = 2,
  parameter bit CLEAR_ON_DONE = 1'b1,
  localparam int SW = slot_w(COLOR_W, OPCODE_W),
  localparam int CW = $clog2(N_BETS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   key_valid,
  input  logic [OPCODE_W-1:0]    key_opcode,
  input  logic [COLOR_W-1:0]     key_color,
  input  logic                   spin_done,
  output logic [N_BETS*SW-1:0]   bets_flat,
  output logic [CW-1:0]          bet_count,
  output logic                   full,
  output logic                   locked,
  output logic                   spin_req,
  output logic                   reject
);
  state_t state, state_nx;
  logic key_evt, push, pop, clr, spin_nx, rej_nx;
  logic is_nokey, is_spin, is_undo, has_bets;
  pulse_edge u_key_edge (.clock(clock), .reset(reset), .din(key_valid), .rise(key_evt));
  assign is_nokey = key_opcode == OPCODE_W'(NO_KEY);
  assign is_spin = key_opcode == OPCODE_W'(SPIN);
  assign is_undo = key_opcode == OPCODE_W'(UNDO);
  assign has_bets = bet_count != '0;
  assign full = bet_count == CW'(N_BETS);
  assign locked = state == LOCKED;
  always_comb begin
    state_nx = state;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    spin_nx = 1'b0;
    rej_nx = 1'b0;
    unique case (state)
      ACCEPT: if (key_evt && !is_nokey) begin
        if (is_spin) begin
          state_nx = has_bets ? LOCKED : ACCEPT;
          spin_nx = has_bets;
          rej_nx = !has_bets;
        end else if (is_undo) begin
          pop = has_bets;
          rej_nx = !has_bets;
        end else begin
          push = key_color != '0 && !full;
          rej_nx = key_color == '0 || full;
        end
      end
      LOCKED: state_nx = spin_done ? (CLEAR_ON_DONE ? CLEAR : ACCEPT) : LOCKED;
      CLEAR: begin
        clr = 1'b1;
        state_nx = ACCEPT;
      end
      default: state_nx = ACCEPT;
    endcase
  end
  always_ff @(posedge clock) begin
    state <= reset ? ACCEPT : state_nx;
    spin_req <= !reset && spin_nx;
    reject <= !reset && rej_nx;
    bet_count <= (reset || clr) ? '0 : push ? bet_count + CW'(1) : pop ? bet_count - CW'(1) : bet_count;
  end
  for (genvar i = 0; i < N_BETS; i++) begin : g_slot
    logic [SW-1:0] slot;
    always_ff @(posedge clock)
      slot <= (reset || clr) ? '0
            : (push && bet_count == CW'(i)) ? {key_color, key_opcode}
            : (pop && bet_count == CW'(i + 1)) ? '0
            : slot;
    assign bets_flat[i*SW +: SW] = slot;
  end
endmodule

// File: tb/tb_bet_ledger.sv
// tb_bet_ledger: directed self-checking bench for bet_ledger (clear and retain variants)
module tb_bet_ledger;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_valid = 1'b0;
  logic [5:0] key_opcode = 6'b111111;
  logic [1:0] key_color = 2'd0;
  logic spin_done = 1'b0;
  logic [95:0] flat0, flat1;
  logic [3:0] cnt0, cnt1;
  logic full0, full1, locked0, locked1, spin0, spin1, rej0, rej1;
  logic rej_a, spin_a, rej_b, spin_b;
  int total = 0;
  int passed = 0;
  always #5 clock = ~clock;
  bet_ledger #(.CLEAR_ON_DONE(1'b1)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_opcode(key_opcode),
    .key_color(key_color), .spin_done(spin_done), .bets_flat(flat0), .bet_count(cnt0),
    .full(full0), .locked(locked0), .spin_req(spin0), .reject(rej0)
  );
  bet_ledger #(.CLEAR_ON_DONE(1'b0)) dut_keep (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_opcode(key_opcode),
    .key_color(key_color), .spin_done(spin_done), .bets_flat(flat1), .bet_count(cnt1),
    .full(full1), .locked(locked1), .spin_req(spin1), .reject(rej1)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic press(input logic [5:0] op, input logic [1:0] col);
    key_opcode = op;
    key_color = col;
    key_valid = 1'b1;
    tick();
    rej_a = rej0;
    spin_a = spin0;
    key_valid = 1'b0;
    tick();
    rej_b = rej0;
    spin_b = spin0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", cnt0, 0);
    chk("rst_flat", flat0, 0);
    chk("rst_full", full0, 0);
    chk("rst_locked", locked0, 0);
    chk("rst_spin", spin0, 0);
    chk("rst_reject", rej0, 0);
    key_opcode = 6'd5;
    key_color = 2'b01;
    key_valid = 1'b1;
    tick();
    chk("hold_first_count", cnt0, 1);
    chk("hold_first_slot0", flat0, 96'h45);
    for (int i = 0; i < 9; i++) tick();
    chk("hold_count", cnt0, 1);
    key_valid = 1'b0;
    tick();
    chk("hold_flat", flat0, 96'h45);
    press(6'b111111, 2'd1);
    chk("nokey_reject", rej_a, 0);
    chk("nokey_count", cnt0, 1);
    do_reset();
    for (int i = 0; i < 12; i++) press(6'(i), 2'(1 + i % 3));
    chk("fill_count", cnt0, 12);
    chk("fill_full", full0, 1);
    chk("fill_slot0", flat0[7:0], 8'h40);
    chk("fill_slot11", flat0[95:88], 8'hCB);
    press(6'd20, 2'd1);
    chk("over_reject", rej_a, 1);
    chk("over_reject_once", rej_b, 0);
    chk("over_count", cnt0, 12);
    chk("over_slot11", flat0[95:88], 8'hCB);
    do_reset();
    press(6'd1, 2'd1);
    press(6'd2, 2'd2);
    press(6'd3, 2'd3);
    chk("undo_start_count", cnt0, 3);
    chk("undo_start_flat", flat0, 96'hC38241);
    press(6'b111101, 2'd0);
    chk("undo1_count", cnt0, 2);
    chk("undo1_flat", flat0, 96'h8241);
    press(6'b111101, 2'd0);
    chk("undo2_count", cnt0, 1);
    chk("undo2_flat", flat0, 96'h41);
    press(6'b111101, 2'd0);
    chk("undo3_count", cnt0, 0);
    chk("undo3_reject", rej_a, 0);
    press(6'b111101, 2'd0);
    chk("undo4_reject", rej_a, 1);
    chk("undo4_count", cnt0, 0);
    chk("undo4_flat", flat0, 0);
    do_reset();
    press(6'd7, 2'd1);
    press(6'd8, 2'd2);
    press(6'b111110, 2'd0);
    chk("spin_req", spin_a, 1);
    chk("spin_req_once", spin_b, 0);
    chk("spin_locked", locked0, 1);
    chk("spin_keep_locked", locked1, 1);
    press(6'd9, 2'd1);
    chk("locked_reject", rej_a, 0);
    chk("locked_count", cnt0, 2);
    chk("locked_flat", flat0, 96'h8847);
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    chk("done_unlocked", locked0, 0);
    chk("done_keep_unlocked", locked1, 0);
    tick();
    chk("clear_count", cnt0, 0);
    chk("clear_flat", flat0, 0);
    chk("keep_count", cnt1, 2);
    chk("keep_flat", flat1, 96'h8847);
    press(6'd10, 2'd3);
    chk("keep_new_count", cnt1, 3);
    chk("keep_new_flat", flat1, 96'hCA8847);
    chk("clear_new_flat", flat0, 96'hCA);
    do_reset();
    press(6'b111110, 2'd1);
    chk("spin_empty_reject", rej_a, 1);
    chk("spin_empty_req", spin_a, 0);
    chk("spin_empty_locked", locked0, 0);
    press(6'd4, 2'd0);
    chk("nocolor_reject", rej_a, 1);
    chk("nocolor_count", cnt0, 0);
    press(6'd1, 2'd1);
    press(6'b111110, 2'd0);
    chk("pre_reset_locked", locked0, 1);
    do_reset();
    chk("reset_locked", locked0, 0);
    chk("reset_count", cnt0, 0);
    chk("reset_flat", flat0, 0);
    press(6'd2, 2'd2);
    chk("post_reset_accept", flat0, 96'h82);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
